bexkat_video_timing: RTL and testbench

//  Raster timing generator directly upstream of the bexkat pixel generator. Produces

---
 rtl/bexkat_video_timing_pkg.sv | 34 +++
 rtl/bexkat_video_timing_if.sv | 31 +++
 rtl/bexkat_video_timing_ce_gen.sv | 36 +++
 rtl/bexkat_video_timing.sv | 106 ++++++++++
 tb/tb_bexkat_video_timing.sv | 289 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/bexkat_video_timing_pkg.sv
// Shared raster defaults, video mode type and mode-dependent line arithmetic
// for the bexkat timing generator and its consumers.
package bexkat_video_pkg;

    localparam int HPOS_W = 9;
    localparam int VPOS_W = 10;

    localparam int CE_DIV_DEF     = 8;
    localparam int H_ACT_DEF      = 320;
    localparam int H_SS_DEF       = 336;
    localparam int H_SW_DEF       = 32;
    localparam int H_TOT_DEF      = 384;
    localparam int V_ACT_DEF      = 240;
    localparam int V_NTSC_TOT_DEF = 262;
    localparam int V_NTSC_VS_DEF  = 244;
    localparam int V_PAL_TOT_DEF  = 312;
    localparam int V_PAL_VS_DEF   = 270;
    localparam int V_SW_DEF       = 3;

    typedef struct packed {
        logic pal;
        logic sd;
    } vmode_t;

    // Scandoubled output runs every 15 kHz line twice, so vertical values double.
    function automatic logic [VPOS_W-1:0] scale(int lines, logic sd);
        return sd ? VPOS_W'(lines * 2) : VPOS_W'(lines);
    endfunction

    function automatic logic [VPOS_W-1:0] vtot(vmode_t m, int ntsc_tot, int pal_tot);
        return scale(m.pal ? pal_tot : ntsc_tot, m.sd);
    endfunction

endpackage

// File: rtl/bexkat_video_timing_if.sv
// Raster timing bundle between the timing generator (master) and the pixel
// stage (slave); mode selects flow toward the generator.
interface bexkat_video_timing_if;
    import bexkat_video_pkg::*;

    logic              pal;
    logic              scandouble;
    logic              ce_pix;
    logic [HPOS_W-1:0] hpos;
    logic [VPOS_W-1:0] vpos;
    logic              de;
    logic              HBlank;
    logic              HSync;
    logic              VBlank;
    logic              VSync;
    logic              line_start;
    logic              frame_start;

    modport master (
        input  pal, scandouble,
        output ce_pix, hpos, vpos, de, HBlank, HSync, VBlank, VSync,
               line_start, frame_start
    );

    modport slave (
        output pal, scandouble,
        input  ce_pix, hpos, vpos, de, HBlank, HSync, VBlank, VSync,
               line_start, frame_start
    );

endinterface

// File: rtl/bexkat_video_timing_ce_gen.sv
// Pixel clock-enable divider: tick marks the last clk of a pixel period,
// ce_pix is the registered one-clk pulse that follows it.
module bexkat_ce_gen #(
    parameter int CE_DIV = 8
) (
    input  logic clk,
    input  logic reset,
    input  logic sd,
    input  logic reload,
    output logic tick,
    output logic ce_pix
);
    localparam int CNT_W = $clog2(CE_DIV);

    logic [CNT_W-1:0] cnt_p1;
    logic [CNT_W-1:0] last_p0;

    assign last_p0 = sd ? CNT_W'(CE_DIV / 2 - 1) : CNT_W'(CE_DIV - 1);
    assign tick    = (cnt_p1 == last_p0);

    // Stage p1: count restarts at every pixel and on a mode switch.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_p1 <= '0;
            ce_pix <= 1'b0;
        end else begin
            ce_pix <= tick;
            if (tick || reload) begin
                cnt_p1 <= '0;
            end else begin
                cnt_p1 <= cnt_p1 + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/bexkat_video_timing.sv
// Raster timing generator: beam counters, blank/sync/de decode and the
// per-frame mode latch, all registered together with ce_pix.
module bexkat_video_timing
    import bexkat_video_pkg::*;
#(
    parameter int CE_DIV   = CE_DIV_DEF,
    parameter int H_ACT    = H_ACT_DEF,
    parameter int H_SS     = H_SS_DEF,
    parameter int H_SW     = H_SW_DEF,
    parameter int H_TOT    = H_TOT_DEF,
    parameter int V_ACT    = V_ACT_DEF,
    parameter int NTSC_TOT = V_NTSC_TOT_DEF,
    parameter int NTSC_VS  = V_NTSC_VS_DEF,
    parameter int PAL_TOT  = V_PAL_TOT_DEF,
    parameter int PAL_VS   = V_PAL_VS_DEF,
    parameter int V_SW     = V_SW_DEF
) (
    input  logic                  clk,
    input  logic                  reset,
    bexkat_video_timing_if.master vid
);
    vmode_t            mode_p0, mode_p1;
    logic              tick, ce_pix;
    logic              h_wrap, v_wrap;
    logic [HPOS_W-1:0] hpos_p0, hpos_p1;
    logic [VPOS_W-1:0] vpos_p0, vpos_p1;
    logic [VPOS_W-1:0] vtot_p1, vact_p0, vs_p0, vsw_p0;
    logic              de_p1, hblank_p1, hsync_p1, vblank_p1, vsync_p1;
    logic              line_start_p1, frame_start_p1;

    bexkat_ce_gen #(.CE_DIV(CE_DIV)) u_ce_gen (
        .clk    (clk),
        .reset  (reset),
        .sd     (mode_p1.sd),
        .reload (tick && v_wrap),
        .tick   (tick),
        .ce_pix (ce_pix)
    );

    assign vtot_p1 = vtot(mode_p1, NTSC_TOT, PAL_TOT);
    assign h_wrap  = (hpos_p1 == HPOS_W'(H_TOT - 1));
    assign v_wrap  = h_wrap && (vpos_p1 == vtot_p1 - VPOS_W'(1));

    // Stage p0: next beam position and the mode that applies to it. Decode
    // uses the incoming mode so the first line of a new frame is already right.
    always_comb begin
        hpos_p0 = h_wrap ? '0 : hpos_p1 + HPOS_W'(1);
        vpos_p0 = vpos_p1;
        if (v_wrap) begin
            vpos_p0 = '0;
        end else if (h_wrap) begin
            vpos_p0 = vpos_p1 + VPOS_W'(1);
        end
        mode_p0 = mode_p1;
        if (v_wrap) begin
            mode_p0.pal = vid.pal;
            mode_p0.sd  = vid.scandouble;
        end
        vact_p0 = scale(V_ACT, mode_p0.sd);
        vs_p0   = scale(mode_p0.pal ? PAL_VS : NTSC_VS, mode_p0.sd);
        vsw_p0  = scale(V_SW, mode_p0.sd);
    end

    // Stage p1: everything moves on the same edge that raises ce_pix.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mode_p1        <= '0;
            hpos_p1        <= '0;
            vpos_p1        <= '0;
            de_p1          <= 1'b0;
            hblank_p1      <= 1'b0;
            hsync_p1       <= 1'b0;
            vblank_p1      <= 1'b0;
            vsync_p1       <= 1'b0;
            line_start_p1  <= 1'b0;
            frame_start_p1 <= 1'b0;
        end else if (tick) begin
            mode_p1        <= mode_p0;
            hpos_p1        <= hpos_p0;
            vpos_p1        <= vpos_p0;
            de_p1          <= (hpos_p0 < HPOS_W'(H_ACT)) && (vpos_p0 < vact_p0);
            hblank_p1      <= (hpos_p0 >= HPOS_W'(H_ACT));
            hsync_p1       <= (hpos_p0 >= HPOS_W'(H_SS)) &&
                              (hpos_p0 < HPOS_W'(H_SS + H_SW));
            vblank_p1      <= (vpos_p0 >= vact_p0);
            vsync_p1       <= (vpos_p0 >= vs_p0) && (vpos_p0 < vs_p0 + vsw_p0);
            line_start_p1  <= h_wrap;
            frame_start_p1 <= v_wrap;
        end else begin
            line_start_p1  <= 1'b0;
            frame_start_p1 <= 1'b0;
        end
    end

    assign vid.ce_pix      = ce_pix;
    assign vid.hpos        = hpos_p1;
    assign vid.vpos        = vpos_p1;
    assign vid.de          = de_p1;
    assign vid.HBlank      = hblank_p1;
    assign vid.HSync       = hsync_p1;
    assign vid.VBlank      = vblank_p1;
    assign vid.VSync       = vsync_p1;
    assign vid.line_start  = line_start_p1;
    assign vid.frame_start = frame_start_p1;

endmodule

// File: tb/tb_bexkat_video_timing.sv
// Directed bench for bexkat_video_timing with a shrunken raster (24x14 NTSC,
// 24x17 PAL) so whole frames fit in a short run; CE_DIV stays at 8.
module tb_bexkat_video_timing;

    localparam int CE_DIV   = 8;
    localparam int H_ACT    = 16;
    localparam int H_SS     = 18;
    localparam int H_SW     = 3;
    localparam int H_TOT    = 24;
    localparam int V_ACT    = 10;
    localparam int NTSC_TOT = 14;
    localparam int NTSC_VS  = 11;
    localparam int PAL_TOT  = 17;
    localparam int PAL_VS   = 12;
    localparam int V_SW     = 2;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    int   n_checks = 0;
    int   n_pass   = 0;
    logic mon_en   = 1'b0;
    logic ls_prev  = 1'b0;
    logic fs_prev  = 1'b0;
    logic [26:0] all_out;

    bexkat_video_timing_if vid();

    bexkat_video_timing #(
        .CE_DIV(CE_DIV), .H_ACT(H_ACT), .H_SS(H_SS), .H_SW(H_SW), .H_TOT(H_TOT),
        .V_ACT(V_ACT), .NTSC_TOT(NTSC_TOT), .NTSC_VS(NTSC_VS),
        .PAL_TOT(PAL_TOT), .PAL_VS(PAL_VS), .V_SW(V_SW)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .vid   (vid)
    );

    always #5 clk = ~clk;

    assign all_out = {vid.ce_pix, vid.hpos, vid.vpos, vid.de, vid.HBlank, vid.HSync,
                      vid.VBlank, vid.VSync, vid.line_start, vid.frame_start};

    // Steady-state invariants, sampled on the falling edge.
    always @(negedge clk) begin
        if (mon_en && !reset) begin
            if (vid.ce_pix) begin
                n_checks++;
                if (vid.de !== !(vid.HBlank | vid.VBlank))
                    $display("FAIL de_vs_blank: de=%b HBlank=%b VBlank=%b at h=%0d v=%0d",
                             vid.de, vid.HBlank, vid.VBlank, vid.hpos, vid.vpos);
                else n_pass++;
            end
            if (vid.frame_start) begin
                n_checks++;
                if (vid.line_start !== 1'b1)
                    $display("FAIL frame_implies_line: line_start=%b, expected 1", vid.line_start);
                else n_pass++;
            end
            if (vid.line_start) begin
                n_checks++;
                if (ls_prev !== 1'b0 || vid.ce_pix !== 1'b1)
                    $display("FAIL line_start_pulse: prev=%b ce=%b, expected prev=0 ce=1",
                             ls_prev, vid.ce_pix);
                else n_pass++;
            end
            if (vid.frame_start) begin
                n_checks++;
                if (fs_prev !== 1'b0)
                    $display("FAIL frame_start_pulse: prev=%b, expected 0", fs_prev);
                else n_pass++;
            end
            ls_prev = vid.line_start;
            fs_prev = vid.frame_start;
        end else begin
            ls_prev = 1'b0;
            fs_prev = 1'b0;
        end
    end

    // Clocks until the selected strobe is seen (0=ce_pix 1=line_start 2=frame_start), -1 on timeout.
    task automatic wait_event(input int which, input int limit, output int n);
        n = -1;
        for (int i = 1; i <= limit; i++) begin
            @(negedge clk);
            if ((which == 0 && vid.ce_pix) || (which == 1 && vid.line_start) ||
                (which == 2 && vid.frame_start)) begin
                n = i;
                break;
            end
        end
    endtask

    // Walks one frame from the current frame_start sample to the next, recording
    // where each decoded signal first/last appears; optionally changes the mode inputs mid-frame.
    task automatic scan_frame(input int tog_line, input logic tog_pal, input logic tog_sd,
                              output int lines, output int hb_first,
                              output int hs_first, output int hs_last,
                              output int vb_first, output int vs_first, output int vs_last,
                              output int gmin, output int gmax);
        int  last_ce, h, v;
        bit  done, toggled;
        lines = 0; hb_first = 999; hs_first = 999; hs_last = -1;
        vb_first = 999; vs_first = 999; vs_last = -1; gmin = 999; gmax = -1;
        last_ce = 0; done = 0; toggled = 0;
        for (int c = 0; c < 8000 && !done; c++) begin
            if (c > 0) @(negedge clk);
            if (c > 0 && vid.frame_start) begin
                done = 1;
            end else if (vid.ce_pix) begin
                h = int'(vid.hpos);
                v = int'(vid.vpos);
                if (c > 0) begin
                    if (c - last_ce < gmin) gmin = c - last_ce;
                    if (c - last_ce > gmax) gmax = c - last_ce;
                end
                last_ce = c;
                if (v + 1 > lines) lines = v + 1;
                if (vid.HBlank && h < hb_first) hb_first = h;
                if (vid.HSync && h < hs_first) hs_first = h;
                if (vid.HSync && h > hs_last) hs_last = h;
                if (vid.VBlank && v < vb_first) vb_first = v;
                if (vid.VSync && v < vs_first) vs_first = v;
                if (vid.VSync && v > vs_last) vs_last = v;
                if (!toggled && tog_line >= 0 && v == tog_line) begin
                    vid.pal        = tog_pal;
                    vid.scandouble = tog_sd;
                    toggled = 1;
                end
            end
        end
        if (!done) lines = -1;
    endtask

    task automatic test_reset();
        int n;
        reset = 1'b1;
        vid.pal = 1'b0;
        vid.scandouble = 1'b0;
        repeat (5) @(posedge clk);
        @(negedge clk);
        n_checks++;
        if (all_out !== 27'd0) $display("FAIL reset_outputs: got %h, expected 0", all_out);
        else n_pass++;
        reset = 1'b0;
        mon_en = 1'b1;
        wait_event(0, 40, n);
        n_checks++;
        if (n !== 8) $display("FAIL first_ce_clk: got %0d, expected 8", n);
        else n_pass++;
        n_checks++;
        if ({vid.hpos, vid.vpos, vid.de, vid.HBlank, vid.line_start} !== {9'd1, 10'd0, 3'b100})
            $display("FAIL first_ce_state: h=%0d v=%0d de=%b hb=%b ls=%b, expected h=1 v=0 de=1 hb=0 ls=0",
                     vid.hpos, vid.vpos, vid.de, vid.HBlank, vid.line_start);
        else n_pass++;
        wait_event(0, 40, n);
        n_checks++;
        if (n !== 8 || vid.hpos !== 9'd2)
            $display("FAIL ce_period: gap=%0d h=%0d, expected gap=8 h=2", n, vid.hpos);
        else n_pass++;
        // 24 pixels * 8 clks = 192 clks per line; 16 clks already consumed.
        wait_event(1, 400, n);
        n_checks++;
        if (n !== 176 || vid.hpos !== 9'd0 || vid.vpos !== 10'd1 || vid.ce_pix !== 1'b1)
            $display("FAIL first_line_start: clk=%0d h=%0d v=%0d ce=%b, expected 176 0 1 1",
                     n, vid.hpos, vid.vpos, vid.ce_pix);
        else n_pass++;
        wait_event(1, 400, n);
        n_checks++;
        if (n !== 192) $display("FAIL line_period: got %0d, expected 192", n);
        else n_pass++;
        // 14 lines * 192 = 2688 clks per frame; 384 already consumed.
        wait_event(2, 4000, n);
        n_checks++;
        if (n !== 2304 || vid.hpos !== 9'd0 || vid.vpos !== 10'd0 || vid.de !== 1'b1)
            $display("FAIL first_frame_start: clk=%0d h=%0d v=%0d de=%b, expected 2304 0 0 1",
                     n, vid.hpos, vid.vpos, vid.de);
        else n_pass++;
    endtask

    task automatic test_ntsc_decode();
        int l, hb, hs0, hs1, vb, vs0, vs1, g0, g1;
        scan_frame(-1, 1'b0, 1'b0, l, hb, hs0, hs1, vb, vs0, vs1, g0, g1);
        n_checks++;
        if (l !== 14) $display("FAIL ntsc_lines: got %0d, expected 14", l);
        else n_pass++;
        n_checks++;
        if (hb !== 16 || hs0 !== 18 || hs1 !== 20)
            $display("FAIL ntsc_hdecode: hb=%0d hs=%0d..%0d, expected 16 18..20", hb, hs0, hs1);
        else n_pass++;
        n_checks++;
        if (vb !== 10 || vs0 !== 11 || vs1 !== 12)
            $display("FAIL ntsc_vdecode: vb=%0d vs=%0d..%0d, expected 10 11..12", vb, vs0, vs1);
        else n_pass++;
        n_checks++;
        if (g0 !== 8 || g1 !== 8) $display("FAIL ntsc_ce_gap: %0d..%0d, expected 8..8", g0, g1);
        else n_pass++;
    endtask

    task automatic test_pal_switch();
        int l, hb, hs0, hs1, vb, vs0, vs1, g0, g1;
        scan_frame(5, 1'b1, 1'b0, l, hb, hs0, hs1, vb, vs0, vs1, g0, g1);
        n_checks++;
        if (l !== 14 || vs0 !== 11) $display("FAIL pal_midframe: lines=%0d vs=%0d, expected 14 11", l, vs0);
        else n_pass++;
        scan_frame(-1, 1'b0, 1'b0, l, hb, hs0, hs1, vb, vs0, vs1, g0, g1);
        n_checks++;
        if (l !== 17) $display("FAIL pal_lines: got %0d, expected 17", l);
        else n_pass++;
        n_checks++;
        if (vb !== 10 || vs0 !== 12 || vs1 !== 13 || hb !== 16)
            $display("FAIL pal_decode: vb=%0d vs=%0d..%0d hb=%0d, expected 10 12..13 16",
                     vb, vs0, vs1, hb);
        else n_pass++;
    endtask

    task automatic test_scandouble();
        int l, hb, hs0, hs1, vb, vs0, vs1, g0, g1;
        scan_frame(5, 1'b0, 1'b1, l, hb, hs0, hs1, vb, vs0, vs1, g0, g1);
        n_checks++;
        if (l !== 17 || g0 !== 8 || g1 !== 8)
            $display("FAIL sd_midframe: lines=%0d gap=%0d..%0d, expected 17 8..8", l, g0, g1);
        else n_pass++;
        scan_frame(-1, 1'b0, 1'b0, l, hb, hs0, hs1, vb, vs0, vs1, g0, g1);
        n_checks++;
        if (l !== 28) $display("FAIL sd_lines: got %0d, expected 28", l);
        else n_pass++;
        n_checks++;
        if (g0 !== 4 || g1 !== 4) $display("FAIL sd_ce_gap: %0d..%0d, expected 4..4", g0, g1);
        else n_pass++;
        n_checks++;
        if (vb !== 20 || vs0 !== 22 || vs1 !== 25 || hs0 !== 18 || hs1 !== 20)
            $display("FAIL sd_decode: vb=%0d vs=%0d..%0d hs=%0d..%0d, expected 20 22..25 18..20",
                     vb, vs0, vs1, hs0, hs1);
        else n_pass++;
    endtask

    task automatic test_async_reset();
        int  n;
        bit  found;
        vid.pal = 1'b0;
        vid.scandouble = 1'b0;
        found = 0;
        for (int i = 0; i < 4000 && !found; i++) begin
            @(negedge clk);
            if (vid.ce_pix && vid.hpos == 9'd12 && vid.vpos == 10'd6) found = 1;
        end
        n_checks++;
        if (!found) $display("FAIL reach_midline: got timeout, expected h=12 v=6");
        else n_pass++;
        #2 reset = 1'b1;
        #1;
        n_checks++;
        if (all_out !== 27'd0) $display("FAIL async_clear: got %h, expected 0", all_out);
        else n_pass++;
        repeat (5) @(posedge clk);
        @(negedge clk);
        n_checks++;
        if (all_out !== 27'd0) $display("FAIL reset_hold: got %h, expected 0", all_out);
        else n_pass++;
        reset = 1'b0;
        wait_event(0, 40, n);
        n_checks++;
        if (n !== 8 || vid.hpos !== 9'd1 || vid.vpos !== 10'd0)
            $display("FAIL restart_ce: clk=%0d h=%0d v=%0d, expected 8 1 0", n, vid.hpos, vid.vpos);
        else n_pass++;
        wait_event(1, 400, n);
        n_checks++;
        if (n !== 184 || vid.vpos !== 10'd1)
            $display("FAIL restart_line: clk=%0d v=%0d, expected 184 1", n, vid.vpos);
        else n_pass++;
        wait_event(2, 4000, n);
        n_checks++;
        if (n !== 2496 || vid.vpos !== 10'd0)
            $display("FAIL restart_frame: clk=%0d v=%0d, expected 2496 0", n, vid.vpos);
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_ntsc_decode();
        test_pal_switch();
        test_scandouble();
        test_async_reset();
        mon_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
